ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode as instruction plus a one-cycle loadInstr strobe.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- I_WIDTH, 32, instruction word width.
- A_WIDTH, 32, fetch address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  fetch request valid.
- imem_addr  output  A_WIDTH  word-aligned fetch address.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid; at most one per granted request, in order, >=1 cycle after gnt.
- imem_rdata  input  I_WIDTH  read data.
- redirect_valid  input  1  branch/jump taken, single-cycle pulse.
- redirect_pc  input  A_WIDTH  new fetch target; bits [1:0] ignored (treated as 0).
- stall  input  1  decode cannot accept an instruction this cycle.
- instruction  output  I_WIDTH  FIFO head word.
- instr_pc  output  A_WIDTH  PC of FIFO head.
- loadInstr  output  1  decode loads instruction this cycle (pop).

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, FIFO empty, outstanding=0, imem_req=0, imem_addr=RESET_PC, instruction=0, instr_pc=0, loadInstr=0.
- At most one outstanding request. The outstanding flag sets on req&gnt and clears on accepted or discarded rvalid.
- imem_req=1 only in FETCH when (fifo_count + outstanding) < FIFO_DEPTH and redirect_valid=0. imem_addr=pc.
- On req&gnt: pc <= pc+4, wrapping modulo 2^A_WIDTH, and the state moves to WAIT.
- WAIT: on rvalid, push {pc_of_request, imem_rdata} into the FIFO, then return to FETCH. A back-to-back request may issue the next cycle.
- Redirect (any state): FIFO flushed, pc <= {redirect_pc[A_WIDTH-1:2],2'b00}, loadInstr forced 0 that cycle.
  - If a request is outstanding and its rvalid is not in the same cycle, go to DRAIN; otherwise go to FETCH.
- DRAIN: imem_req=0. The next rvalid is discarded (no push), then go to FETCH.
  - A second redirect while in DRAIN only updates pc.
- loadInstr = FIFO non-empty & !stall & !redirect_valid (combinational). instruction and instr_pc show the FIFO head combinationally; both are 0 when the FIFO is empty.
- Simultaneous push and pop with the FIFO full: the pop frees a slot and the push is accepted. Overflow cannot occur because of the request throttle.
- Push into an empty FIFO is visible to decode the next cycle, not bypassed. Fetch-to-decode latency is gnt cycle + memory latency + 1.
- Reset asserted mid-transaction: all state clears asynchronously. A late rvalid after reset release with outstanding=0 is ignored.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined: adds output fetch_count[31:0], counting FIFO pushes, and output stall_count[31:0], counting cycles with FIFO non-empty & stall. Both reset to 0, wrap at 2^32, and are unaffected by redirect.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- riscv_pkg holds: the ifetch_state_e enum (FETCH, WAIT, DRAIN), the fetch_entry_t struct {pc, instr}, RESET_PC_DEFAULT, and the NOP constant 32'h0000_0013.
- One sub-module, ifetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full outputs. Flush has priority over push in the same cycle.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, rdata=addr+0x100 -> requests to 0x0,0x4,0x8; first loadInstr with instruction=0x100, instr_pc=0x0; continuous throughput one word per 2 cycles.
- stall held high for 10 cycles -> at most 2 entries buffered, imem_req drops to 0, no loadInstr. Stall release -> entries 0x0,0x4 delivered in order, no loss.
- Redirect to 0x1002 while a request to 0x8 is outstanding -> rvalid for 0x8 discarded, next request addr=0x1000, FIFO previously holding entries is empty next cycle.
- Redirect in the same cycle as rvalid -> response dropped, go to FETCH directly, next imem_addr=redirect target.
- pc=0xFFFF_FFFC fetch granted -> next imem_addr=0x0000_0000.
- Assert rst_n low while in WAIT, then a late rvalid after release -> ignored, FIFO empty, imem_addr=RESET_PC. With IFETCH_PERF_CNT_EN, fetch_count=0 after reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: fetch FSM states, fetch buffer entry, constants.
// Used by ifetch_unit and ifetch_fifo.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer of fetch_entry_t; flush wins over push in the same cycle.
// Ports: i_push/i_entry write, i_pop read, i_flush clear, o_head/o_count/o_empty/o_full.
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_empty,
    output logic         o_full
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // A pop in the same cycle frees the slot a full-buffer push needs.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_entry;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem req/gnt/rvalid, prefetch buffer, redirects.
// Ports: clk, rst_n, imem_* memory side, redirect_*, stall, instruction/instr_pc/loadInstr
// to decode. `IFETCH_PERF_CNT_EN adds fetch_count and stall_count outputs.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int               I_WIDTH    = 32,
    parameter int               A_WIDTH    = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [I_WIDTH-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    input  logic               stall,
    output logic [I_WIDTH-1:0] instruction,
    output logic [A_WIDTH-1:0] instr_pc,
    output logic               loadInstr
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    localparam int           CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    ifetch_state_e      r_state;
    logic [A_WIDTH-1:0] r_pc;
    logic [A_WIDTH-1:0] r_req_pc;
    logic               r_out;
    logic               r_run;

    logic [CW-1:0]      w_count;
    logic [CW:0]        w_occ;
    logic               w_empty;
    logic               w_full;
    fetch_entry_t       w_head;
    fetch_entry_t       w_entry;
    logic               w_req;
    logic               w_fire;
    logic               w_rv;
    logic               w_push;
    logic               w_pop;
    logic [A_WIDTH-1:0] w_tgt;

    // Slots already promised to an in-flight request count as occupied.
    assign w_occ = {1'b0, w_count} + {{CW{1'b0}}, r_out};

    // r_run holds imem_req low while in reset and for the release cycle.
    assign w_req  = r_run & (r_state == FETCH) & (w_occ < DEPTH_L)
                  & ~w_full & ~redirect_valid;
    assign w_fire = w_req & imem_gnt;
    assign w_rv   = imem_rvalid & r_out;
    assign w_push = w_rv & (r_state == WAIT) & ~redirect_valid;
    assign w_pop  = ~w_empty & ~stall & ~redirect_valid;
    assign w_tgt  = redirect_pc & ~A_WIDTH'(3);

    assign w_entry.pc    = r_req_pc;
    assign w_entry.instr = imem_rdata;

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign loadInstr   = w_pop;
    assign instruction = w_empty ? '0 : w_head.instr;
    assign instr_pc    = w_empty ? '0 : w_head.pc;

    ifetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_out    <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                // A response landing with the redirect is simply dropped.
                r_pc    <= w_tgt;
                r_out   <= r_out & ~imem_rvalid;
                r_state <= (r_out & ~imem_rvalid) ? DRAIN : FETCH;
            end else begin
                unique case (r_state)
                    FETCH: begin
                        if (w_fire) begin
                            r_pc     <= r_pc + A_WIDTH'(4);
                            r_req_pc <= r_pc;
                            r_out    <= 1'b1;
                            r_state  <= WAIT;
                        end
                    end
                    WAIT, DRAIN: begin
                        if (w_rv) begin
                            r_out   <= 1'b0;
                            r_state <= FETCH;
                        end
                    end
                    default: r_state <= FETCH;
                endcase
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (w_push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (~w_empty & stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue model of the fetch stage plus
// a one-outstanding memory responder; directed scenarios with literal checks.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        loadInstr;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    ifetch_unit #(
        .I_WIDTH        (32),
        .A_WIDTH        (32),
        .RESET_PC       (RST_PC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .loadInstr      (loadInstr)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: fetch PC, buffered {pc,instr} words, pending request.
    logic [31:0] m_pc;
    logic [31:0] m_ppc;
    bit          m_pend;
    bit          m_disc;
    bit          m_run;
    logic [63:0] m_q[$];
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    // Memory responder: rvalid `lat` cycles after the grant, rdata = addr+0x100.
    bit          mem_busy = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 0;
    int          lat      = 1;
    bit          gnt_en   = 1;

    logic [31:0] fire_q[$];
    logic [63:0] load_q[$];
    int          load_cyc[$];
    bit          last_fire;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fget(input int i);
        return (i < fire_q.size()) ? fire_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [63:0] lget(input int i);
        return (i < load_q.size()) ? load_q[i] : 64'hx;
    endfunction

    function automatic int cget(input int i);
        return (i < load_cyc.size()) ? load_cyc[i] : -100;
    endfunction

    function automatic void model_reset();
        m_pc   = RST_PC;
        m_ppc  = RST_PC;
        m_pend = 0;
        m_disc = 0;
        m_run  = 0;
        m_q.delete();
        m_fc   = 0;
        m_sc   = 0;
    endfunction

    task automatic cycle();
        logic        e_req;
        logic        e_load;
        logic [31:0] e_ins;
        logic [31:0] e_ipc;
        logic [31:0] f_addr;
        bit          ne;
        imem_rvalid = mem_busy && (mem_wait == 0);
        imem_rdata  = mem_addr + 32'h100;
        imem_gnt    = gnt_en;
        #1;
        if (!rst_n) model_reset();
        ne     = (m_q.size() > 0);
        e_req  = rst_n && m_run && !m_pend && (m_q.size() < DEPTH)
               && !redirect_valid;
        e_load = rst_n && ne && !stall && !redirect_valid;
        e_ins  = ne ? m_q[0][31:0]  : 32'h0;
        e_ipc  = ne ? m_q[0][63:32] : 32'h0;
        chk("imem_req",    imem_req,    e_req);
        chk("imem_addr",   imem_addr,   m_pc);
        chk("loadInstr",   loadInstr,   e_load);
        chk("instruction", instruction, e_ins);
        chk("instr_pc",    instr_pc,    e_ipc);
`ifdef IFETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_fc);
        chk("stall_count", stall_count, m_sc);
`endif
        last_fire = imem_req && imem_gnt;
        f_addr    = imem_addr;
        if (last_fire) fire_q.push_back(imem_addr);
        if (loadInstr) begin
            load_q.push_back({instr_pc, instruction});
            load_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (e_load) m_q.delete(0);
            if (ne && stall) m_sc++;
            if (redirect_valid) begin
                m_q.delete();
                if (m_pend) begin
                    if (imem_rvalid) begin
                        m_pend = 0;
                        m_disc = 0;
                    end else begin
                        m_disc = 1;
                    end
                end
                m_pc = redirect_pc & ~32'h3;
            end else if (m_pend && imem_rvalid) begin
                if (!m_disc) begin
                    m_q.push_back({m_ppc, imem_rdata});
                    m_fc++;
                end
                m_pend = 0;
                m_disc = 0;
            end else if (e_req && imem_gnt) begin
                m_pend = 1;
                m_ppc  = m_pc;
                m_pc   = m_pc + 32'd4;
            end
            m_run = 1;
        end
        if (imem_rvalid) mem_busy = 0;
        else if (mem_busy) mem_wait--;
        if (last_fire) begin
            mem_busy = 1;
            mem_wait = lat - 1;
            mem_addr = f_addr;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_fire();
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!last_fire && k < 20);
        chk("wait_fire", last_fire, 1'b1);
    endtask

    initial begin
        int          nf;
        int          nl;
        logic [31:0] lastpc;
        logic [63:0] e;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RST_PC);
        rst_n = 1'b1;

        // Streaming from reset with one-cycle memory latency.
        repeat (14) cycle();
        chk("t1_fire0", fget(0), 32'h0);
        chk("t1_fire1", fget(1), 32'h4);
        chk("t1_fire2", fget(2), 32'h8);
        chk("t1_load0", lget(0), {32'h0, 32'h100});
        chk("t1_rate0", cget(1) - cget(0), 2);
        chk("t1_rate1", cget(2) - cget(1), 2);

        // Decode stalled: buffer fills, requests stop, order preserved.
        nl     = load_q.size();
        e      = lget(nl - 1);
        lastpc = e[63:32];
        stall  = 1'b1;
        repeat (10) cycle();
        chk("t2_req_low", imem_req, 1'b0);
        chk("t2_no_load", load_q.size() - nl, 0);
        stall = 1'b0;
        repeat (8) cycle();
        chk("t2_next0", lget(nl),     {lastpc + 32'd4, lastpc + 32'h104});
        chk("t2_next1", lget(nl + 1), {lastpc + 32'd8, lastpc + 32'h108});

        // Redirect with a request outstanding and a word buffered.
        lat   = 3;
        stall = 1'b1;
        repeat (10) cycle();
        stall = 1'b0;
        cycle();
        stall = 1'b1;
        wait_fire();
        cycle();
        chk("t3_buffered", |instruction, 1'b1);
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1002;
        nl             = load_q.size();
        cycle();
        chk("t3_flushed_ins", instruction, 32'h0);
        chk("t3_flushed_pc",  instr_pc,    32'h0);
        redirect_valid = 1'b0;
        lat            = 1;
        nf             = fire_q.size();
        repeat (10) cycle();
        chk("t3_target",  fget(nf), 32'h1000);
        chk("t3_first",   lget(nl), {32'h1000, 32'h1100});

        // Redirect in the same cycle the response arrives.
        wait_fire();
        nl             = load_q.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        cycle();
        redirect_valid = 1'b0;
        nf             = fire_q.size();
        cycle();
        chk("t4_direct", fget(nf), 32'h2000);
        repeat (4) cycle();
        chk("t4_first", lget(nl), {32'h2000, 32'h2100});

        // PC wrap; low redirect bits ignored.
        nl             = load_q.size();
        nf             = fire_q.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        repeat (8) cycle();
        chk("t5_top",  fget(nf),     32'hFFFF_FFFC);
        chk("t5_wrap", fget(nf + 1), 32'h0000_0000);
        chk("t5_load", lget(nl),     {32'hFFFF_FFFC, 32'h0000_00FC});

        // Reset while waiting; the stale response arrives after release.
        lat = 4;
        wait_fire();
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("t6_rst_addr", imem_addr, RST_PC);
        chk("t6_rst_req",  imem_req,  1'b0);
        gnt_en = 0;
        rst_n  = 1'b1;
        nl     = load_q.size();
        repeat (6) cycle();
        chk("t6_no_load", load_q.size() - nl, 0);
        chk("t6_empty",   instruction, 32'h0);
        chk("t6_addr",    imem_addr,   RST_PC);
`ifdef IFETCH_PERF_CNT_EN
        chk("t6_fcount",  fetch_count, 32'h0);
`endif
        gnt_en = 1;
        lat    = 1;
        nf     = fire_q.size();
        repeat (4) cycle();
        chk("t6_refetch", fget(nf), RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
